// File: rtl/debug_controller_pkg.sv
// Shared constants for the debug controller: command bytes, FSM encoding, dump length.
// The optional cycle counter is enabled by defining DEBUG_CYCLE_COUNT_EN.
package debug_controller_pkg;

  localparam logic [7:0] CmdRun   = 8'h43;  // 'C'
  localparam logic [7:0] CmdStep  = 8'h53;  // 'S'
  localparam logic [7:0] CmdDump  = 8'h44;  // 'D'
  localparam logic [7:0] CmdReset = 8'h52;  // 'R'

`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int unsigned DumpLen = 136;
`else
  localparam int unsigned DumpLen = 132;
`endif

  localparam logic [7:0] DumpLastIdx = 8'(DumpLen - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2,
    StDump = 2'd3
  } state_e;

endpackage

// File: rtl/dump_serializer.sv
// Byte-index to dump-byte mux: PC, reg0..reg31, then the cycle counter, each 4 bytes MSB first.
module dump_serializer #(
  parameter int unsigned PROC_BITS = 32,
  parameter int unsigned PC_BITS   = 32
) (
  input  logic [7:0]              byte_idx,
  input  logic [PC_BITS-1:0]      pc,
  input  logic [32*PROC_BITS-1:0] rf_regs,
  input  logic [31:0]             cycle_cnt,
  output logic [7:0]              tx_byte
);

  logic [31:0] pc_w;
  logic [31:0] reg_w [32];
  logic [31:0] word;
  logic [5:0]  word_sel;
  logic [4:0]  reg_sel;

  // Every dumped word is 32 bits regardless of the configured widths.
  if (PC_BITS >= 32) begin : g_pc_trunc
    assign pc_w = pc[31:0];
  end else begin : g_pc_ext
    assign pc_w = {{(32-PC_BITS){1'b0}}, pc};
  end

  for (genvar i = 0; i < 32; i++) begin : g_reg
    if (PROC_BITS >= 32) begin : g_trunc
      assign reg_w[i] = rf_regs[i*PROC_BITS +: 32];
    end else begin : g_ext
      assign reg_w[i] = {{(32-PROC_BITS){1'b0}}, rf_regs[i*PROC_BITS +: PROC_BITS]};
    end
  end

  assign word_sel = byte_idx[7:2];
  assign reg_sel  = 5'(word_sel - 6'd1);

  always_comb begin
    word = cycle_cnt;
    if (word_sel == 6'd0) begin
      word = pc_w;
    end else if (word_sel <= 6'd32) begin
      word = reg_w[reg_sel];
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    case (byte_idx[1:0])
      2'd0: tx_byte = word[31:24];
      2'd1: tx_byte = word[23:16];
      2'd2: tx_byte = word[15:8];
      2'd3: tx_byte = word[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/debug_controller.sv
// UART-driven run/step/dump debug controller for a simple pipelined core.
// Define DEBUG_CYCLE_COUNT_EN to count enabled cycles and append the count to the dump.
module debug_controller
  import debug_controller_pkg::*;
#(
  parameter int unsigned PROC_BITS = 32,
  parameter int unsigned PC_BITS   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_proc_enable,
  output logic                    o_proc_reset,
  input  logic                    i_halt,
  input  logic [PC_BITS-1:0]      i_pc,
  input  logic [32*PROC_BITS-1:0] i_rf_regs,
  output logic                    o_busy
);

  state_e      state_q, state_d;
  logic [7:0]  byte_idx_q, byte_idx_d;
  logic        proc_reset_q;
  logic        cmd_valid;
  logic        cmd_reset;
  logic        tx_fire;
  logic [7:0]  ser_byte;
  logic [31:0] cycle_cnt;

  assign cmd_valid     = (state_q == StIdle) && i_rx_valid;
  assign cmd_reset     = cmd_valid && (i_rx_data == CmdReset);
  assign o_proc_enable = (state_q == StRun) || (state_q == StStep);
  assign o_busy        = (state_q != StIdle);
  assign o_tx_valid    = (state_q == StDump);
  assign o_tx_data     = o_tx_valid ? ser_byte : 8'h00;
  assign o_proc_reset  = proc_reset_q;
  assign tx_fire       = o_tx_valid && i_tx_ready;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (i_rx_data)
            CmdRun:  state_d = StRun;
            CmdStep: state_d = StStep;
            CmdDump: state_d = StDump;
            default: state_d = StIdle;
          endcase
        end
      end
      StRun: begin
        if (i_halt) state_d = StDump;
      end
      StStep: begin
        state_d = StDump;
      end
      StDump: begin
        if (tx_fire) begin
          if (byte_idx_q == DumpLastIdx) begin
            byte_idx_d = 8'd0;
            state_d    = StIdle;
          end else begin
            byte_idx_d = byte_idx_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      byte_idx_q   <= 8'd0;
      proc_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      proc_reset_q <= cmd_reset;
    end
  end

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= 32'd0;
    end else if (cmd_reset) begin
      cycle_cnt_q <= 32'd0;
    end else if (o_proc_enable) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`else
  assign cycle_cnt = 32'd0;
`endif

  // Datapath is stalled during the dump, so PC and registers are read live.
  dump_serializer #(
    .PROC_BITS (PROC_BITS),
    .PC_BITS   (PC_BITS)
  ) u_dump_serializer (
    .byte_idx  (byte_idx_q),
    .pc        (i_pc),
    .rf_regs   (i_rf_regs),
    .cycle_cnt (cycle_cnt),
    .tx_byte   (ser_byte)
  );

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller: command table, step/run/dump sequences, mid-dump reset.
module tb_debug_controller;

`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int DumpLen = 136;
`else
  localparam int DumpLen = 132;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic         proc_enable;
  logic         proc_reset;
  logic         halt = 1'b0;
  logic [31:0]  pc = 32'h0000_0010;
  logic [1023:0] rf_flat = '0;
  logic         busy;

  logic [31:0]  regs [32];
  logic [31:0]  exp_cnt = 32'd0;
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  debug_controller #(
    .PROC_BITS (32),
    .PC_BITS   (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .o_tx_data     (tx_data),
    .o_tx_valid    (tx_valid),
    .i_tx_ready    (tx_ready),
    .o_proc_enable (proc_enable),
    .o_proc_reset  (proc_reset),
    .i_halt        (halt),
    .i_pc          (pc),
    .i_rf_regs     (rf_flat),
    .o_busy        (busy)
  );

  typedef struct {
    logic [7:0] rx;
    logic       exp_reset;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int idx);
    logic [31:0] w;
    if (idx < 4) w = pc;
    else if (idx < 132) w = regs[(idx - 4) / 4];
    else w = exp_cnt;
    w = w >> (8 * (3 - (idx % 4)));
    return w[7:0];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Issue cmd, then watch enable and the dump until tx_valid falls.
  // ready_mode 1 drives i_tx_ready with the repeating pattern 1,0,0,1.
  task automatic run_and_dump(input logic [7:0] cmd, input int halt_at, input int ready_mode,
                              input int inject_at, input int exp_en, input string tag);
    int   en = 0;
    int   n = 0;
    int   c = 0;
    bit   started = 0;
    bit   done = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    @(negedge clk);
    rx_data  = cmd;
    rx_valid = 1'b1;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      halt     = 1'b0;
      if (proc_enable) begin
        en++;
        if (en == halt_at) halt = 1'b1;
      end
      if (tx_valid) begin
        started = 1;
        if (prev_stall) check({tag, "_stall_hold"}, {24'h0, tx_data}, {24'h0, prev_data});
        tx_ready = (ready_mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
        if (c == inject_at) begin
          rx_data  = 8'h53;
          rx_valid = 1'b1;
        end
        if (tx_ready) begin
          check({tag, "_byte"}, {24'h0, tx_data}, {24'h0, exp_byte(n)});
          n++;
        end
        prev_stall = !tx_ready;
        prev_data  = tx_data;
        c++;
      end else if (started) begin
        done = 1;
      end
    end
    tx_ready = 1'b1;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: dump did not finish, %0d bytes seen", tag, n);
    end
    check({tag, "_enable_cycles"}, en, exp_en);
    check({tag, "_byte_count"}, n, DumpLen);
    check({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
    check({tag, "_tx_data_after"}, {24'h0, tx_data}, 32'h0);
  endtask

  vec_t vecs[6];
  int   guard;
  int   sent;

  initial begin
    regs[0] = 32'h0000_0000;
    regs[1] = 32'hDEAD_BEEF;
    for (int i = 2; i < 32; i++) regs[i] = {i[7:0], 8'hA5, ~i[7:0], 8'h3C};
    for (int i = 0; i < 32; i++) rf_flat[i*32 +: 32] = regs[i];

    vecs[0] = '{rx: 8'h7A, exp_reset: 1'b0};
    vecs[1] = '{rx: 8'h00, exp_reset: 1'b0};
    vecs[2] = '{rx: 8'hFF, exp_reset: 1'b0};
    vecs[3] = '{rx: 8'h63, exp_reset: 1'b0};
    vecs[4] = '{rx: 8'h52, exp_reset: 1'b1};
    vecs[5] = '{rx: 8'h7A, exp_reset: 1'b0};

    #12;
    check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("reset_tx_data", {24'h0, tx_data}, 32'h0);
    check("reset_enable", {31'h0, proc_enable}, 32'h0);
    check("reset_proc_reset", {31'h0, proc_reset}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", {31'h0, busy}, 32'h0);

    // Idle commands that must not leave IDLE
    for (int v = 0; v < 6; v++) begin
      send_byte(vecs[v].rx);
      check("vec_busy", {31'h0, busy}, 32'h0);
      check("vec_enable", {31'h0, proc_enable}, 32'h0);
      check("vec_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("vec_proc_reset", {31'h0, proc_reset}, {31'h0, vecs[v].exp_reset});
      @(negedge clk);
      check("vec_proc_reset_end", {31'h0, proc_reset}, 32'h0);
    end

    exp_cnt = 32'd1;
    run_and_dump(8'h53, 0, 0, -1, 1, "step");

    send_byte(8'h52);
    check("r_pulse", {31'h0, proc_reset}, 32'h1);
    exp_cnt = 32'h15;
    run_and_dump(8'h43, 21, 0, -1, 21, "run");

    // Stalled dump with an 'S' that must be dropped
    run_and_dump(8'h44, 0, 1, 5, 0, "dump_stall");

    // Reset in the middle of a dump
    @(negedge clk);
    rx_data  = 8'h44;
    rx_valid = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    sent  = 0;
    guard = 0;
    while (sent < 50 && guard < 200) begin
      if (tx_valid) sent++;
      @(negedge clk);
      guard++;
    end
    check("mid_dump_valid", {31'h0, tx_valid}, 32'h1);
    check("mid_dump_byte50", {24'h0, tx_data}, {24'h0, exp_byte(50)});
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_tx_data", {24'h0, tx_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 32'd0;
    run_and_dump(8'h44, 0, 0, -1, 0, "restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
